// File: rtl/board_scanner.sv
// ---------------------------------------------------------------------------
// board_scanner
//
// Read-side counterpart of the board update path. On a frame request it
// snapshots the packed 81-cell board and visibility vectors, then streams
// one cell per valid/ready handshake in row-major order to the render
// driver. At frame end it publishes the number of revealed cells and a
// solved flag for the game FSM.
//
// Optional feature macro: SCANNER_HINT_EN
//    defined   : cell_match flags revealed cells whose digit equals the
//                live selected_number
//    undefined : cell_match is tied to 0, no comparator is built
//
// Parameters
//    HIDDEN_DIGIT    digit reported for cells with visibility code 2'b00
//    AUTO_RESTART    when 1, a new frame starts the cycle after frame_done
//
// Ports
//    clk, reset        system clock, asynchronous active-high reset
//    start             frame request, only looked at in IDLE
//    board             cell k digit at board[4k +: 4], k = 9*row + col
//    visibilities      cell k code at visibilities[2k +: 2]
//                      (00 hidden, 01 cursor, 10 error, 11 revealed)
//    selected_number   number currently chosen by the player
//    cell_valid/ready  beat handshake towards the render driver
//    cell_row/col      position of the current beat (0..8)
//    cell_digit        digit of the current beat, HIDDEN_DIGIT if hidden
//    cell_style        visibility code of the current beat
//    cell_match        hint flag (see macro above)
//    busy              high while a frame is being streamed
//    frame_done        one-cycle pulse at frame end
//    revealed_count    revealed cells in the last completed frame
//    solved            revealed_count == 81 for the last completed frame
// ---------------------------------------------------------------------------
module board_scanner #(
   parameter logic [3:0] HIDDEN_DIGIT = 4'd0,
   parameter bit         AUTO_RESTART = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [323:0] board,
   input  logic [161:0] visibilities,
   input  logic [3:0]   selected_number,
   output logic         cell_valid,
   input  logic         cell_ready,
   output logic [3:0]   cell_row,
   output logic [3:0]   cell_col,
   output logic [3:0]   cell_digit,
   output logic [1:0]   cell_style,
   output logic         cell_match,
   output logic         busy,
   output logic         frame_done,
   output logic [6:0]   revealed_count,
   output logic         solved
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t         state;
   logic [323:0]   board_snap;
   logic [161:0]   vis_snap;
   logic [3:0]     row_cnt;
   logic [3:0]     col_cnt;
   logic [6:0]     cell_idx;
   logic [6:0]     acc;

   logic [3:0]     raw_digit;
   logic [1:0]     raw_style;
   logic           xfer;
   logic           last_cell;
   logic [6:0]     acc_next;

   // The current beat is read straight out of the snapshot using a linear
   // cell index kept alongside row/col, which avoids a 9*row+col multiply.
   // Outside a frame the beat fields are forced to 0 so idle outputs are clean.
   always_comb begin
      raw_digit = board_snap[{cell_idx, 2'b00} +: 4];
      raw_style = vis_snap[{cell_idx, 1'b0} +: 2];
      xfer      = cell_valid && cell_ready;
      last_cell = (row_cnt == 4'd8) && (col_cnt == 4'd8);
      acc_next  = acc + {6'd0, (raw_style == 2'b11)};
      cell_row  = row_cnt;
      cell_col  = col_cnt;
      cell_style = cell_valid ? raw_style : 2'b00;
      if (!cell_valid)
         cell_digit = 4'd0;
      else if (raw_style == 2'b00)
         cell_digit = HIDDEN_DIGIT;
      else
         cell_digit = raw_digit;
   end

`ifdef SCANNER_HINT_EN
   // The hint uses the live selected_number so a change of selection shows
   // up on the very next beat without waiting for a new frame.
   assign cell_match = (cell_style == 2'b11) && (cell_digit == selected_number);
`else
   logic unused_selected;
   assign unused_selected = ^selected_number;
   assign cell_match      = 1'b0;
`endif

   // Main FSM. A frame start (from IDLE, or from DONE when auto-restarting)
   // latches the inputs and clears counters and the accumulator on the same
   // edge, so cell 0 is presented on the following cycle. The frame result is
   // loaded on the edge that transfers cell 80, so revealed_count and solved
   // are already valid while frame_done is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         board_snap     <= '0;
         vis_snap       <= '0;
         row_cnt        <= 4'd0;
         col_cnt        <= 4'd0;
         cell_idx       <= 7'd0;
         acc            <= 7'd0;
         cell_valid     <= 1'b0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         revealed_count <= 7'd0;
         solved         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               frame_done <= 1'b0;
               if (start) begin
                  state      <= SCAN;
                  board_snap <= board;
                  vis_snap   <= visibilities;
                  row_cnt    <= 4'd0;
                  col_cnt    <= 4'd0;
                  cell_idx   <= 7'd0;
                  acc        <= 7'd0;
                  cell_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            SCAN: begin
               if (xfer) begin
                  acc <= acc_next;
                  if (last_cell) begin
                     state          <= DONE;
                     row_cnt        <= 4'd0;
                     col_cnt        <= 4'd0;
                     cell_idx       <= 7'd0;
                     cell_valid     <= 1'b0;
                     busy           <= 1'b0;
                     frame_done     <= 1'b1;
                     revealed_count <= acc_next;
                     solved         <= (acc_next == 7'd81);
                  end else begin
                     cell_idx <= cell_idx + 7'd1;
                     if (col_cnt == 4'd8) begin
                        col_cnt <= 4'd0;
                        row_cnt <= row_cnt + 4'd1;
                     end else begin
                        col_cnt <= col_cnt + 4'd1;
                     end
                  end
               end
            end
            DONE: begin
               frame_done <= 1'b0;
               if (AUTO_RESTART) begin
                  state      <= SCAN;
                  board_snap <= board;
                  vis_snap   <= visibilities;
                  row_cnt    <= 4'd0;
                  col_cnt    <= 4'd0;
                  cell_idx   <= 7'd0;
                  acc        <= 7'd0;
                  cell_valid <= 1'b1;
                  busy       <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               cell_valid <= 1'b0;
               busy       <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_board_scanner.sv
// ---------------------------------------------------------------------------
// tb_board_scanner
//
// Scoreboard bench for board_scanner. Each frame request pushes the 81
// expected beats (computed from the board/visibility vectors being driven)
// into a queue; a negedge monitor pops and compares every transferred beat
// and checks that stalled beats hold still. Frame-level results are
// compared against constants taken from the intended behaviour.
// ---------------------------------------------------------------------------
module tb_board_scanner;

   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
      logic [3:0] digit;
      logic [1:0] style;
   } beat_t;

   logic         clk;
   logic         reset;
   logic         start;
   logic [323:0] board;
   logic [161:0] visibilities;
   logic [3:0]   selected_number;
   logic         cell_valid;
   logic         cell_ready;
   logic [3:0]   cell_row;
   logic [3:0]   cell_col;
   logic [3:0]   cell_digit;
   logic [1:0]   cell_style;
   logic         cell_match;
   logic         busy;
   logic         frame_done;
   logic [6:0]   revealed_count;
   logic         solved;

   int checkCount = 0;
   int failCount  = 0;
   int beatCount  = 0;
   beat_t expQ[$];
   bit    prevStall = 0;
   logic [14:0] heldBeat;

   board_scanner dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .board(board),
      .visibilities(visibilities),
      .selected_number(selected_number),
      .cell_valid(cell_valid),
      .cell_ready(cell_ready),
      .cell_row(cell_row),
      .cell_col(cell_col),
      .cell_digit(cell_digit),
      .cell_style(cell_style),
      .cell_match(cell_match),
      .busy(busy),
      .frame_done(frame_done),
      .revealed_count(revealed_count),
      .solved(solved)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Load one of the board/visibility test patterns
   task automatic applyStimulus(input int pattern);
      for (int k = 0; k < 81; k++) begin
         board[4*k +: 4] = 4'((k % 9) + 1);
         if (pattern == 1 && k < 10)
            visibilities[2*k +: 2] = 2'b00;
         else if (pattern == 1 && k == 10)
            visibilities[2*k +: 2] = 2'b10;
         else
            visibilities[2*k +: 2] = 2'b11;
      end
   endtask

   // Push the expected beats of a frame based on the inputs driven right now
   task automatic pushExpected();
      beat_t e;
      for (int k = 0; k < 81; k++) begin
         e.row   = 4'(k / 9);
         e.col   = 4'(k % 9);
         e.style = visibilities[2*k +: 2];
         e.digit = (e.style == 2'b00) ? 4'd0 : board[4*k +: 4];
         expQ.push_back(e);
      end
   endtask

   // Monitor: compare every transferred beat and check stalled beats hold
   always @(negedge clk) begin
      beat_t e;
      logic  expMatch;
      if (prevStall)
         checkOutput("stall_hold", {17'd0, cell_valid, cell_row, cell_col, cell_digit, cell_style},
                     {17'd0, heldBeat});
      prevStall = cell_valid && !cell_ready;
      heldBeat  = {cell_valid, cell_row, cell_col, cell_digit, cell_style};
      if (cell_valid && cell_ready) begin
         beatCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("cell_row", cell_row, e.row);
            checkOutput("cell_col", cell_col, e.col);
            checkOutput("cell_digit", cell_digit, e.digit);
            checkOutput("cell_style", cell_style, e.style);
`ifdef SCANNER_HINT_EN
            expMatch = (e.style == 2'b11) && (e.digit == selected_number);
`else
            expMatch = 1'b0;
`endif
            checkOutput("cell_match", cell_match, expMatch);
         end
      end
   end

   // Run one frame: mode 0 = ready always high, mode 1 = ready 1,0,0,1 cycle.
   // changeBeat >= 0 rewrites board cell 80 to 7 once that many beats passed.
   // startPulseAt >= 0 pulses start during the scan (must be ignored).
   task automatic runFrame(input int mode, input int changeBeat, input int startPulseAt,
                           input int expRev, input int expDoneCyc);
      int cyc;
      int doneCyc;
      bit doneSeen;
      bit changed;
      logic [3:0] readyPat;
      readyPat = 4'b1001;
      cyc      = 0;
      doneCyc  = -1;
      doneSeen = 0;
      changed  = 0;
      pushExpected();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      beatCount = 0;
      while (!doneSeen && cyc < 1000) begin
         cell_ready = (mode == 0) ? 1'b1 : readyPat[cyc % 4];
         start      = (cyc == startPulseAt);
         if (changeBeat >= 0 && !changed && beatCount >= changeBeat) begin
            board[323:320] = 4'd7;
            changed = 1;
         end
         @(negedge clk);
         if (frame_done) begin
            doneSeen = 1;
            doneCyc  = cyc;
            checkOutput("revealed_count", revealed_count, expRev);
            checkOutput("solved", solved, 32'(expRev == 81));
            checkOutput("done_valid", cell_valid, 0);
            checkOutput("done_busy", busy, 0);
         end
         @(posedge clk); #1;
         cyc++;
      end
      start      = 1'b0;
      cell_ready = 1'b1;
      checkOutput("frame_timeout", doneSeen, 1);
      if (expDoneCyc >= 0)
         checkOutput("done_latency", doneCyc, expDoneCyc);
      checkOutput("beat_total", beatCount, 81);
      checkOutput("queue_empty", expQ.size(), 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_valid", cell_valid, 0);
      checkOutput("idle_done", frame_done, 0);
      checkOutput("hold_count", revealed_count, expRev);
   endtask

   // Start a frame and assert reset asynchronously while cell 40 is shown
   task automatic resetMidFrame();
      int cyc;
      cyc = 0;
      pushExpected();
      cell_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      beatCount = 0;
      while (beatCount < 40 && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("reach_cell40", 32'(beatCount >= 40), 1);
      checkOutput("cell40_col", cell_col, 4);
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_valid", cell_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_row", cell_row, 0);
      checkOutput("rst_col", cell_col, 0);
      checkOutput("rst_digit", cell_digit, 0);
      checkOutput("rst_style", cell_style, 0);
      checkOutput("rst_match", cell_match, 0);
      checkOutput("rst_done", frame_done, 0);
      checkOutput("rst_count", revealed_count, 0);
      checkOutput("rst_solved", solved, 0);
      expQ.delete();
      prevStall = 0;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("post_rst_valid", cell_valid, 0);
   endtask

   initial begin
      reset           = 1'b1;
      start           = 1'b0;
      cell_ready      = 1'b1;
      selected_number = 4'd5;
      board           = '0;
      visibilities    = '0;
      applyStimulus(0);
      #23;
      checkOutput("por_valid", cell_valid, 0);
      checkOutput("por_busy", busy, 0);
      checkOutput("por_count", revealed_count, 0);
      checkOutput("por_solved", solved, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] full scan, ready high");
      runFrame(0, -1, -1, 81, 81);

      $display("[TB] backpressure with ignored start");
      runFrame(1, -1, 5, 81, -1);

      $display("[TB] snapshot: cell 80 changes during the frame");
      runFrame(0, 10, -1, 81, 81);
      runFrame(0, -1, -1, 81, 81);

      $display("[TB] hidden and error cells");
      applyStimulus(1);
      runFrame(1, -1, -1, 70, -1);

      $display("[TB] reset mid-frame then restart");
      applyStimulus(0);
      resetMidFrame();
      runFrame(0, -1, -1, 81, 81);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/board_scanner.md
Name: board_scanner

Overview:
Read-side counterpart of the board update path. On request, snapshots the packed 81-cell board and visibility vectors and streams one cell per handshake, in row-major order, to the display/render driver. Each cell carries row, col, digit and display style. At frame end it publishes a revealed-cell count and a solved flag for the game FSM.

Parameters:
HIDDEN_DIGIT, 4'd0, digit value reported for cells whose visibility is 2'b00.
AUTO_RESTART, 0, when 1 the next frame starts automatically the cycle after frame_done.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  frame request, sampled only in IDLE
board  input  324  cell k digit at board[4k +: 4], k = 9*row + col
visibilities  input  162  cell k code at visibilities[2k +: 2]: 00 hidden, 01 cursor, 10 error, 11 revealed
selected_number  input  4  number currently chosen by the player (1..9)
cell_valid  output  1  cell beat valid
cell_ready  input  1  driver accepts beat
cell_row  output  4  0..8
cell_col  output  4  0..8
cell_digit  output  4  digit, or HIDDEN_DIGIT if hidden
cell_style  output  2  copy of the visibility code
cell_match  output  1  hint flag (see Optional Feature)
busy  output  1  high in SCAN
frame_done  output  1  one-cycle pulse at frame end
revealed_count  output  7  cells with code 11 in the last completed frame
solved  output  1  revealed_count == 81 for the last completed frame

Behaviour:
- Reset: state IDLE. All outputs 0, including revealed_count and solved. Snapshot registers and counters cleared. Reset is asynchronous and takes effect mid-frame, abandoning the frame with no frame_done.
- States: IDLE -> SCAN on start. SCAN -> DONE on the handshake of cell 80. DONE -> IDLE, or -> SCAN if AUTO_RESTART=1, which re-snapshots the inputs on that edge.
- Snapshot: on the IDLE->SCAN edge, board and visibilities are latched internally. Input changes during SCAN do not affect the frame in progress. selected_number is not snapshotted.
- Latency: start high at edge N gives cell_valid=1 with cell 0 (row 0, col 0) from cycle N+1.
- Handshake: a beat transfers when cell_valid && cell_ready. While valid and not ready, all cell_* outputs hold stable. Throughput is 1 cell/cycle. With cell_ready held high, a frame takes exactly 81 valid cycles.
- Counters: col increments per transfer. col 8 wraps to 0 and increments row. After row 8/col 8 transfers, cell_valid drops the next cycle. Counters never exceed 8.
- Accumulator: an internal 7-bit count increments on each transferred cell with style 11, and is cleared at frame start.
- DONE, one cycle: frame_done=1. revealed_count and solved load from the accumulator. They hold until the next DONE.
- busy = 1 in SCAN only. start is ignored in SCAN and DONE, with no queuing.
- cell_digit: the raw 4-bit snapshot value for codes 01/10/11. Out-of-range values (0, 10..15) pass through unchanged.

Optional Feature:
SCANNER_HINT_EN
- Defined: cell_match = (style == 11) && (digit == selected_number), evaluated combinationally on the current beat using the live selected_number.
- Undefined: cell_match is tied to 0 and no comparator is built.

Test Plan:
- Reset: assert reset mid-frame at cell 40 -> next cycle all outputs 0, state IDLE. A following start restarts at row 0/col 0.
- Full scan, ready=1: board with cell k digit = (k%9)+1, all visibilities 11 -> 81 beats with correct row/col/digit, frame_done at cycle 82 after start, revealed_count=81, solved=1.
- Backpressure: ready toggles 1,0,0,1 -> beats stall with stable data, no cell skipped or repeated, 81 transfers total.
- Snapshot: change board cell 80 to 4'd7 at beat 10 -> streamed cell 80 shows the old value. The next frame shows 7.
- Hidden/error: cells 0..9 code 00, cell 10 code 10, rest 11 -> cells 0..9 digit HIDDEN_DIGIT with style 00, cell 10 style 10, revealed_count=70, solved=0.
- Hint (SCANNER_HINT_EN): selected_number=5 -> cell_match=1 only on revealed cells with digit 5. Without the macro, cell_match is always 0.
